// File: rtl/gpr_wb.sv
`default_nettype none
// ============================================================================
// Module      : gpr_wb
// Description : Write-back sequencer for the GPR file write port. Accepts
//               results from the CSR path (priority) and the execute path over
//               valid/ready, queues them in a circular FIFO and retires one
//               register write per cycle. Offers a combinational bypass lookup
//               over queued and in-flight results.
// Config      : GPR_WB_BYPASS_EN - when defined, the bypass search logic is
//               built; when undefined, byp_* outputs are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module gpr_wb #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exe_valid,
  output logic        exe_ready,
  input  logic [4:0]  exe_rd,
  input  logic [31:0] exe_data,
  input  logic        csr_valid,
  output logic        csr_ready,
  input  logic [4:0]  csr_rd,
  input  logic [31:0] csr_rdata,
  output logic        gpr_we,
  output logic [4:0]  gpr_rd,
  output logic [31:0] gpr_di,
  input  logic [4:0]  byp_ra,
  input  logic [4:0]  byp_rb,
  output logic        byp_hit_a,
  output logic        byp_hit_b,
  output logic [31:0] byp_data_a,
  output logic [31:0] byp_data_b,
  output logic        wb_idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // FIFO storage; contents need no reset because validity comes from the pointers
  logic [4:0]    rd_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic          full;
  logic          empty;
  logic          csr_take;
  logic          exe_take;
  logic          push;
  logic          pop;
  logic [4:0]    push_rd;
  logic [31:0]   push_data;

  // Extra pointer MSB distinguishes full from empty when the index bits match
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Ready is based on occupancy only, never on a same-cycle pop
  assign csr_ready = !full;
  assign exe_ready = !full && !csr_valid;

  assign csr_take  = csr_valid && csr_ready;
  assign exe_take  = exe_valid && exe_ready;
  assign push_rd   = csr_take ? csr_rd    : exe_rd;
  assign push_data = csr_take ? csr_rdata : exe_data;

  // A handshake to x0 completes but is dropped here so no write is ever issued
  assign push = (csr_take || exe_take) && (push_rd != 5'd0);
  assign pop  = !empty;

  assign wb_idle = empty && !gpr_we;

  // Store the accepted result at the write pointer
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr[AW-1:0]]   <= push_rd;
      data_mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Advance pointers and load the register-file write port from the FIFO head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      gpr_we <= 1'b0;
      gpr_rd <= 5'd0;
      gpr_di <= 32'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        gpr_we <= 1'b1;
        gpr_rd <= rd_mem[rd_ptr[AW-1:0]];
        gpr_di <= data_mem[rd_ptr[AW-1:0]];
      end else begin
        gpr_we <= 1'b0;
      end
    end
  end

`ifdef GPR_WB_BYPASS_EN
  logic [PW-1:0] count;
  assign count = wr_ptr - rd_ptr;

  // Search the output register, then FIFO entries oldest to newest so the
  // newest match overrides earlier ones
  always_comb begin
    logic [AW-1:0] slot;
    slot       = '0;
    byp_hit_a  = 1'b0;
    byp_hit_b  = 1'b0;
    byp_data_a = 32'd0;
    byp_data_b = 32'd0;
    if (gpr_we && (gpr_rd == byp_ra) && (byp_ra != 5'd0)) begin
      byp_hit_a  = 1'b1;
      byp_data_a = gpr_di;
    end
    if (gpr_we && (gpr_rd == byp_rb) && (byp_rb != 5'd0)) begin
      byp_hit_b  = 1'b1;
      byp_data_b = gpr_di;
    end
    for (int k = 0; k < DEPTH; k++) begin
      slot = rd_ptr[AW-1:0] + AW'(k);
      if (PW'(k) < count) begin
        if ((rd_mem[slot] == byp_ra) && (byp_ra != 5'd0)) begin
          byp_hit_a  = 1'b1;
          byp_data_a = data_mem[slot];
        end
        if ((rd_mem[slot] == byp_rb) && (byp_rb != 5'd0)) begin
          byp_hit_b  = 1'b1;
          byp_data_b = data_mem[slot];
        end
      end
    end
  end
`else
  // Without bypass the operand stage stalls on wb_idle instead
  logic unused_byp;
  assign unused_byp = ^{byp_ra, byp_rb};
  assign byp_hit_a  = 1'b0;
  assign byp_hit_b  = 1'b0;
  assign byp_data_a = 32'd0;
  assign byp_data_b = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gpr_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpr_wb
// Description : Self-checking bench for gpr_wb: directed vector table, hand
//               sequences (back-to-back pushes, CSR burst, mid-run reset) and
//               randomized traffic against a queue-based reference model.
//               Bypass expectations follow GPR_WB_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpr_wb;

  localparam int DEPTH = 4;
`ifdef GPR_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exe_valid;
  logic        exe_ready;
  logic [4:0]  exe_rd;
  logic [31:0] exe_data;
  logic        csr_valid;
  logic        csr_ready;
  logic [4:0]  csr_rd;
  logic [31:0] csr_rdata;
  logic        gpr_we;
  logic [4:0]  gpr_rd;
  logic [31:0] gpr_di;
  logic [4:0]  byp_ra;
  logic [4:0]  byp_rb;
  logic        byp_hit_a;
  logic        byp_hit_b;
  logic [31:0] byp_data_a;
  logic [31:0] byp_data_b;
  logic        wb_idle;

  gpr_wb #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .exe_valid  (exe_valid),
    .exe_ready  (exe_ready),
    .exe_rd     (exe_rd),
    .exe_data   (exe_data),
    .csr_valid  (csr_valid),
    .csr_ready  (csr_ready),
    .csr_rd     (csr_rd),
    .csr_rdata  (csr_rdata),
    .gpr_we     (gpr_we),
    .gpr_rd     (gpr_rd),
    .gpr_di     (gpr_di),
    .byp_ra     (byp_ra),
    .byp_rb     (byp_rb),
    .byp_hit_a  (byp_hit_a),
    .byp_hit_b  (byp_hit_b),
    .byp_data_a (byp_data_a),
    .byp_data_b (byp_data_b),
    .wb_idle    (wb_idle)
  );

  always #5 clk = ~clk;

  // Reference model: pending results as a queue plus the output register
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t      mq[$];
  entry_t      sb[$];
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_di;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        ev;
    logic [4:0]  erd;
    logic [31:0] edat;
    logic        cv;
    logic [4:0]  crd;
    logic [31:0] cdat;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        x_erdy;
    logic        x_crdy;
    logic        x_we;
    logic [4:0]  x_rd;
    logic [31:0] x_di;
    logic        x_idle;
    logic        x_ha;
    logic [31:0] x_da;
    logic        x_hb;
    logic [31:0] x_db;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic ev, input logic [4:0] erd, input logic [31:0] edat,
    input logic cv, input logic [4:0] crd, input logic [31:0] cdat,
    input logic [4:0] ra, input logic [4:0] rb,
    input logic erdy, input logic crdy, input logic we, input logic [4:0] rd,
    input logic [31:0] di, input logic idle, input logic ha, input logic [31:0] da,
    input logic hb, input logic [31:0] db);
    vec_t v;
    v.ev = ev; v.erd = erd; v.edat = edat;
    v.cv = cv; v.crd = crd; v.cdat = cdat;
    v.ra = ra; v.rb = rb;
    v.x_erdy = erdy; v.x_crdy = crdy; v.x_we = we; v.x_rd = rd; v.x_di = di;
    v.x_idle = idle; v.x_ha = ha; v.x_da = da; v.x_hb = hb; v.x_db = db;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic set_in(input logic ev, input logic [4:0] erd, input logic [31:0] edat,
                        input logic cv, input logic [4:0] crd, input logic [31:0] cdat,
                        input logic [4:0] ra, input logic [4:0] rb);
    exe_valid = ev; exe_rd = erd; exe_data = edat;
    csr_valid = cv; csr_rd = crd; csr_rdata = cdat;
    byp_ra = ra; byp_rb = rb;
  endtask

  task automatic model_reset();
    mq.delete();
    sb.delete();
    m_we = 1'b0;
    m_rd = 5'd0;
    m_di = 32'd0;
  endtask

  // One clock edge of the model: retire the oldest pending result, then
  // append whatever was accepted (CSR first, x0 dropped)
  task automatic model_edge();
    bit     full;
    bit     acc_c;
    bit     acc_e;
    entry_t e;
    if (!rst_n) begin
      model_reset();
      return;
    end
    full  = (mq.size() == DEPTH);
    acc_c = csr_valid && !full;
    acc_e = exe_valid && !full && !csr_valid;
    if (mq.size() > 0) begin
      e    = mq.pop_front();
      m_we = 1'b1;
      m_rd = e.rd;
      m_di = e.data;
    end else begin
      m_we = 1'b0;
    end
    if (acc_c && csr_rd != 5'd0) begin
      e.rd = csr_rd; e.data = csr_rdata;
      mq.push_back(e); sb.push_back(e);
    end else if (acc_e && exe_rd != 5'd0) begin
      e.rd = exe_rd; e.data = exe_data;
      mq.push_back(e); sb.push_back(e);
    end
  endtask

  // Newest pending result for an address; queue beats the output register
  task automatic mlook(input logic [4:0] a, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = 32'd0;
    if (a != 5'd0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].rd == a) begin
          h = 1'b1;
          d = mq[i].data;
          break;
        end
      end
      if (!h && m_we && m_rd == a) begin
        h = 1'b1;
        d = m_di;
      end
    end
    h = h & BYP;
    d = BYP ? d : 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic check_model(input int idx);
    logic        ha;
    logic        hb;
    logic [31:0] da;
    logic [31:0] db;
    entry_t      e;
    mlook(byp_ra, ha, da);
    mlook(byp_rb, hb, db);
    chk("m_exe_ready", idx, exe_ready, !(mq.size() == DEPTH) && !csr_valid);
    chk("m_csr_ready", idx, csr_ready, !(mq.size() == DEPTH));
    chk("m_gpr_we", idx, gpr_we, m_we);
    chk("m_gpr_rd", idx, gpr_rd, m_rd);
    chk("m_gpr_di", idx, gpr_di, m_di);
    chk("m_wb_idle", idx, wb_idle, (mq.size() == 0) && !m_we);
    chk("m_hit_a", idx, byp_hit_a, ha);
    chk("m_data_a", idx, byp_data_a, da);
    chk("m_hit_b", idx, byp_hit_b, hb);
    chk("m_data_b", idx, byp_data_b, db);
    if (gpr_we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_extra_write", idx, gpr_rd, 32'd0);
        if (gpr_rd == 5'd0) begin
          errors++;
          $display("FAIL sb_extra_write[%0d]: got write to x0, expected none", idx);
        end
      end else begin
        e = sb.pop_front();
        chk("sb_rd", idx, gpr_rd, e.rd);
        chk("sb_di", idx, gpr_di, e.data);
      end
    end
  endtask

  // Simulation watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    // Directed table: inputs for the cycle, expected outputs sampled in it
    //            ev erd   edat          cv crd  cdat    ra    rb     erdy crdy we rd    di            idle ha da            hb db
    tbl[0]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0, 5'd0, 5'd0,  1, 1, 0, 5'd0, 32'h0,        1, 0, 32'h0,        0, 32'h0);
    tbl[1]  = mk(1, 5'd5, 32'h12345678, 0, 5'd0, 32'h0, 5'd5, 5'd0,  1, 1, 0, 5'd0, 32'h0,        1, 0, 32'h0,        0, 32'h0);
    tbl[2]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0, 5'd5, 5'd0,  1, 1, 0, 5'd0, 32'h0,        0, 1, 32'h12345678, 0, 32'h0);
    tbl[3]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0, 5'd5, 5'd0,  1, 1, 1, 5'd5, 32'h12345678, 0, 1, 32'h12345678, 0, 32'h0);
    tbl[4]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0, 5'd5, 5'd0,  1, 1, 0, 5'd5, 32'h12345678, 1, 0, 32'h0,        0, 32'h0);
    tbl[5]  = mk(1, 5'd1, 32'hA,        1, 5'd2, 32'hB, 5'd2, 5'd1,  0, 1, 0, 5'd5, 32'h12345678, 1, 0, 32'h0,        0, 32'h0);
    tbl[6]  = mk(1, 5'd1, 32'hA,        0, 5'd0, 32'h0, 5'd2, 5'd1,  1, 1, 0, 5'd5, 32'h12345678, 0, 1, 32'hB,        0, 32'h0);
    tbl[7]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0, 5'd2, 5'd1,  1, 1, 1, 5'd2, 32'hB,        0, 1, 32'hB,        1, 32'hA);
    tbl[8]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0, 5'd2, 5'd1,  1, 1, 1, 5'd1, 32'hA,        0, 0, 32'h0,        1, 32'hA);
    tbl[9]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0, 5'd2, 5'd1,  1, 1, 0, 5'd1, 32'hA,        1, 0, 32'h0,        0, 32'h0);
    tbl[10] = mk(1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'h0, 5'd0, 5'd0,  1, 1, 0, 5'd1, 32'hA,        1, 0, 32'h0,        0, 32'h0);
    tbl[11] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0, 5'd0, 5'd0,  1, 1, 0, 5'd1, 32'hA,        1, 0, 32'h0,        0, 32'h0);
    tbl[12] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0, 5'd0, 5'd0,  1, 1, 0, 5'd1, 32'hA,        1, 0, 32'h0,        0, 32'h0);
    tbl[13] = mk(1, 5'd3, 32'h1,        0, 5'd0, 32'h0, 5'd3, 5'd0,  1, 1, 0, 5'd1, 32'hA,        1, 0, 32'h0,        0, 32'h0);
    tbl[14] = mk(1, 5'd3, 32'h2,        0, 5'd0, 32'h0, 5'd3, 5'd0,  1, 1, 0, 5'd1, 32'hA,        0, 1, 32'h1,        0, 32'h0);
    tbl[15] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0, 5'd3, 5'd0,  1, 1, 1, 5'd3, 32'h1,        0, 1, 32'h2,        0, 32'h0);
    tbl[16] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0, 5'd3, 5'd0,  1, 1, 1, 5'd3, 32'h2,        0, 1, 32'h2,        0, 32'h0);
    tbl[17] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0, 5'd3, 5'd0,  1, 1, 0, 5'd3, 32'h2,        1, 0, 32'h0,        0, 32'h0);

    // Reset state
    rst_n = 1'b0;
    set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0, 5'd0);
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_gpr_we", 0, gpr_we, 1'b0);
    chk("rst_gpr_rd", 0, gpr_rd, 5'd0);
    chk("rst_gpr_di", 0, gpr_di, 32'd0);
    chk("rst_wb_idle", 0, wb_idle, 1'b1);
    chk("rst_hit_a", 0, byp_hit_a, 1'b0);
    chk("rst_data_a", 0, byp_data_a, 32'd0);
    chk("rst_csr_ready", 0, csr_ready, 1'b1);
    chk("rst_exe_ready", 0, exe_ready, 1'b1);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      v = tbl[i];
      set_in(v.ev, v.erd, v.edat, v.cv, v.crd, v.cdat, v.ra, v.rb);
      #1;
      chk("t_exe_ready", i, exe_ready, v.x_erdy);
      chk("t_csr_ready", i, csr_ready, v.x_crdy);
      chk("t_gpr_we", i, gpr_we, v.x_we);
      chk("t_gpr_rd", i, gpr_rd, v.x_rd);
      chk("t_gpr_di", i, gpr_di, v.x_di);
      chk("t_wb_idle", i, wb_idle, v.x_idle);
      chk("t_hit_a", i, byp_hit_a, BYP & v.x_ha);
      chk("t_data_a", i, byp_data_a, BYP ? v.x_da : 32'd0);
      chk("t_hit_b", i, byp_hit_b, BYP & v.x_hb);
      chk("t_data_b", i, byp_data_b, BYP ? v.x_db : 32'd0);
      tick();
    end
    sb.delete();

    // Back-to-back execute pushes: pop keeps pace so ready never drops
    for (int i = 0; i < 6; i++) begin
      set_in(1, 5'(i + 7), 32'hC0DE_0000 + 32'(i), 0, 5'd0, 32'h0, 5'(i + 7), 5'(i + 6));
      #1;
      chk("b2b_exe_ready", i, exe_ready, 1'b1);
      check_model(100 + i);
      tick();
    end

    // CSR burst with execute held valid: execute waits for a CSR gap
    for (int i = 0; i < 10; i++) begin
      set_in(1, 5'd20, 32'hEEEE_0020, (i != 7), 5'(16 + (i % 3)), 32'hCCCC_0000 + 32'(i), 5'd20, 5'(16 + (i % 3)));
      #1;
      chk("burst_exe_ready", i, exe_ready, (i == 7));
      check_model(200 + i);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd20, 5'd16);
      #1;
      check_model(300 + i);
      tick();
    end
    chk("burst_sb_drained", 0, 32'(sb.size()), 32'd0);

    // Reset mid-operation with work in flight
    for (int i = 0; i < 3; i++) begin
      set_in(1, 5'(9 + i), 32'hDEAD_0000 + 32'(i), 0, 5'd0, 32'h0, 5'd10, 5'd11);
      #1;
      check_model(400 + i);
      tick();
    end
    set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd10, 5'd11);
    #1;
    check_model(403);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_gpr_we", 0, gpr_we, 1'b0);
    chk("mid_rst_gpr_rd", 0, gpr_rd, 5'd0);
    chk("mid_rst_gpr_di", 0, gpr_di, 32'd0);
    chk("mid_rst_wb_idle", 0, wb_idle, 1'b1);
    chk("mid_rst_hit_b", 0, byp_hit_b, 1'b0);
    chk("mid_rst_data_b", 0, byp_data_b, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_model(500 + i);
      chk("post_rst_no_write", i, gpr_we, 1'b0);
      tick();
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
             1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)), $urandom,
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      #1;
      check_model(1000 + i);
      tick();
    end
    set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_model(2000 + i);
      tick();
    end
    chk("rand_sb_drained", 0, 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gpr_wb.md
# gpr_wb

Write-back sequencer that sits in front of the general-purpose register file write port and is the only block allowed to drive it. It accepts completed results from the execute path and the CSR path over valid/ready handshakes and queues them in a small FIFO. It then issues exactly one register write per cycle on the `gpr_we`/`gpr_rd`/`gpr_di` port. It also exposes a bypass lookup so the operand-read stage can see results that are queued but not yet written.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, 2..16.
- `clk`  in  1: system clock. All state updates on its rising edge.
- `rst_n`  in  1: reset; asynchronous assert, active-low.
- `exe_valid`  in  1: execute-path result offered.
- `exe_ready`  out  1: execute-path result accepted this edge if `exe_valid` is also high.
- `exe_rd`  in  5: execute-path destination register.
- `exe_data`  in  32: execute-path result.
- `csr_valid`  in  1: CSR-read result offered.
- `csr_ready`  out  1: CSR result accepted this edge if `csr_valid` is also high.
- `csr_rd`  in  5: CSR-path destination register.
- `csr_rdata`  in  32: CSR read data.
- `gpr_we`  out  1: write strobe to the register file; registered.
- `gpr_rd`  out  5: write address; registered.
- `gpr_di`  out  32: write data; registered.
- `byp_ra`, `byp_rb`  in  5 each: operand addresses to look up.
- `byp_hit_a`, `byp_hit_b`  out  1 each: a pending write exists for the address.
- `byp_data_a`, `byp_data_b`  out  32 each: newest pending data for the address.
- `wb_idle`  out  1: FIFO empty and `gpr_we` low.

## Operation
- FIFO control:
  - Circular FIFO of DEPTH entries, each holding {rd, data}.
  - Pointers are log2(DEPTH)+1 bits. Full when the MSBs differ and the rest are equal; empty when the pointers are equal.
- Arbitration:
  - At most one push per cycle; CSR has fixed priority over execute.
  - `csr_ready = !full`.
  - `exe_ready = !full && !csr_valid`.
  - Ready does not depend on a same-cycle pop: at full, ready stays low even while popping.
- x0 handling:
  - A handshake with rd = 0 completes normally (ready is honoured), but nothing is enqueued.
  - No `gpr_we` pulse is ever produced for x0.
- Pop and write:
  - Each edge with the FIFO non-empty pops the head into the output register and sets `gpr_we` = 1 for the following cycle.
  - An edge with the FIFO empty clears `gpr_we` to 0; `gpr_rd`/`gpr_di` hold their last values.
  - Push and pop in the same edge are both performed; the count is unchanged.
- Bypass:
  - Candidates are the output register when `gpr_we` = 1, plus every valid FIFO entry.
  - When several candidates match, the newest wins (newest FIFO entry beats older entries; FIFO beats the output register).
  - Address 0 never hits.
  - On a miss, hit = 0 and data = 0.
  - Lookup is purely combinational from the current state.
- Reset (all outputs asynchronous to `rst_n` low):
  - Pointers cleared; `gpr_we` = 0, `gpr_rd` = 0, `gpr_di` = 0.
  - All `byp_*` outputs = 0; `wb_idle` = 1.
  - `exe_ready` = `csr_ready` = 1 once `rst_n` is high (FIFO empty).
  - Reset mid-operation discards queued entries without issuing writes.

## Timing
- Latency:
  - A result accepted at edge N into an empty FIFO is popped at edge N+1.
  - `gpr_we`/`gpr_rd`/`gpr_di` are valid for the cycle between edges N+1 and N+2.
- Throughput:
  - Sustained one write per cycle; back-to-back pops give a continuous `gpr_we` high.
- Bypass visibility:
  - A result hits from the cycle after its acceptance edge through the last cycle `gpr_we` is high for it.
  - The register file covers the address from then on.
- Register-file contract:
  - The register file samples its write on the cycle `gpr_we` is high.
  - `gpr_rd`/`gpr_di` are stable for that entire cycle.

## Configuration
- `GPR_WB_BYPASS_EN`:
  - Defined: bypass search logic is built as described.
  - Undefined: no comparators are built; `byp_hit_a`/`byp_hit_b` are tied 0 and `byp_data_a`/`byp_data_b` tied 0. The pipeline must stall on pending hazards, using `wb_idle`.

## Test plan
- Single write: exe rd = 5, data = 0x12345678, one cycle with empty FIFO -> `gpr_we` high for exactly one cycle, two edges later, with rd = 5, di = 0x12345678; `wb_idle` returns to 1.
- Priority: exe (rd = 1, 0xA) and csr (rd = 2, 0xB) valid in the same cycle -> csr accepted first, `exe_ready` low that cycle; writes appear in order rd = 2 then rd = 1 on consecutive cycles.
- Full boundary, DEPTH = 4: hold `gpr_we` consumer irrelevant. Push 6 results in consecutive cycles -> ready never drops, since pop keeps pace. Then with bursts from both sources (csr every cycle, exe stalled) -> exe accepted only when `csr_valid` is low; no entry lost or duplicated (scoreboard compare).
- x0 discard: exe rd = 0, data = 0xFFFFFFFF accepted -> no `gpr_we` pulse; `byp_ra` = 0 -> `byp_hit_a` = 0.
- Bypass newest-wins (macro defined): queue rd = 3 with 0x1, then rd = 3 with 0x2, `byp_ra` = 3 -> hit = 1, data = 0x2 until the second write retires, then hit = 0. Same stimulus with the macro undefined -> hit = 0, data = 0 throughout.
- Reset mid-operation: 3 entries queued, assert `rst_n` low between edges -> `gpr_we` drops to 0 immediately, no further writes after release, `wb_idle` = 1.
